// File: rtl/soc_nios2_gen2_1_cpu_debug_pkg.sv
// Shared definitions for the Nios II debug memory executor: state encoding and jdo field positions.
package soc_nios2_gen2_1_cpu_debug_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } exec_state_t;

  localparam int JDO_AUTORD    = 34;
  localparam int JDO_CLRERR    = 35;
  localparam int JDO_WDATA_LSB = 3;
  localparam int JDO_ADDR_LSB  = 2;

endpackage

// File: rtl/soc_nios2_gen2_1_cpu_debug_bus_timer.sv
// Stall timer for debug bus transfers; expired pulses on the TIMEOUT-th consecutive stalled cycle.
module soc_nios2_gen2_1_cpu_debug_bus_timer #(
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LAST_CNT = TIMEOUT_W'(TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (count_en) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Terminal compare one below TIMEOUT so the request is held for exactly TIMEOUT stalls.
  assign expired = count_en && (count_q == LAST_CNT);

endmodule

// File: rtl/soc_nios2_gen2_1_cpu_debug_mem_exec.sv
// System-clock executor for JTAG debug memory commands: single-word Avalon-MM reads and writes.
//  state    | meaning
//  ST_IDLE  | no transfer, monitor_ready=1, strobes accepted
//  ST_READ  | avm_read held until !avm_waitrequest or timeout
//  ST_WRITE | avm_write held until !avm_waitrequest or timeout
module soc_nios2_gen2_1_cpu_debug_mem_exec
  import soc_nios2_gen2_1_cpu_debug_pkg::*;
#(
  parameter int ADDR_W    = 30,
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [ADDR_W+1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  exec_state_t       state_q, state_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic              timer_clear;
  logic              timer_expired;
  logic              busy;
  logic              any_strobe;

  assign busy       = (state_q != ST_IDLE);
  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  soc_nios2_gen2_1_cpu_debug_bus_timer #(
    .TIMEOUT  (TIMEOUT),
    .TIMEOUT_W(TIMEOUT_W)
  ) u_bus_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .count_en(busy && avm_waitrequest),
    .expired (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    mon_a_d     = mon_a_q;
    mon_d_d     = mon_d_q;
    wdata_d     = wdata_q;
    ready_d     = ready_q;
    error_d     = error_q;
    timer_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (take_action_ocimem_b) begin
          wdata_d     = jdo[JDO_WDATA_LSB +: 32];
          state_d     = ST_WRITE;
          ready_d     = 1'b0;
          timer_clear = 1'b1;
        end else if (take_action_ocimem_a) begin
          mon_a_d = jdo[JDO_ADDR_LSB +: ADDR_W];
          if (jdo[JDO_CLRERR]) error_d = 1'b0;
          if (jdo[JDO_AUTORD]) begin
            state_d     = ST_READ;
            ready_d     = 1'b0;
            timer_clear = 1'b1;
          end
        end else if (take_no_action_ocimem_a) begin
          state_d     = ST_READ;
          ready_d     = 1'b0;
          timer_clear = 1'b1;
        end
      end
      ST_READ, ST_WRITE: begin
        // Commands arriving mid-transfer are lost; flag them so the host knows.
        if (any_strobe) error_d = 1'b1;
        if (!avm_waitrequest) begin
          mon_d_d = (state_q == ST_READ) ? avm_readdata : wdata_q;
          mon_a_d = mon_a_q + 1'b1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else if (timer_expired) begin
          error_d = 1'b1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mon_a_q <= '0;
      mon_d_q <= '0;
      wdata_q <= '0;
      ready_q <= 1'b1;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mon_a_q <= mon_a_d;
      mon_d_q <= mon_d_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

  // Request lines decode straight from the state register so reset drops them without a clock.
  assign avm_read       = (state_q == ST_READ);
  assign avm_write      = (state_q == ST_WRITE);
  assign avm_address    = busy ? {mon_a_q, 2'b00} : '0;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = 4'hF;
  assign MonDReg        = mon_d_q;
  assign monitor_ready  = ready_q;
  assign monitor_error  = error_q;

endmodule

// File: tb/tb_soc_nios2_gen2_1_cpu_debug_mem_exec.sv
// Self-checking bench: directed vector table, hand-written corner sequences, random run against a transaction model.
module tb_soc_nios2_gen2_1_cpu_debug_mem_exec;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        ta_a, ta_b, tna_a;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;
  logic [31:0] avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  soc_nios2_gen2_1_cpu_debug_mem_exec dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .jdo                    (jdo),
    .take_action_ocimem_a   (ta_a),
    .take_action_ocimem_b   (ta_b),
    .take_no_action_ocimem_a(tna_a),
    .MonDReg                (MonDReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error),
    .avm_address            (avm_address),
    .avm_read               (avm_read),
    .avm_write              (avm_write),
    .avm_writedata          (avm_writedata),
    .avm_byteenable         (avm_byteenable),
    .avm_readdata           (avm_readdata),
    .avm_waitrequest        (avm_waitrequest)
  );

  typedef struct {
    logic        a, b, na;
    logic [37:0] j;
    logic        stall;
    logic [31:0] rdata;
    logic        e_ready, e_rd, e_wr, e_err;
    logic [31:0] e_addr, e_dreg, e_wdata;
  } vec_t;

  vec_t vecs[17];

  function automatic logic [37:0] mk_a(input logic [29:0] ad, input logic ar, input logic ce);
    return {2'b00, ce, ar, 2'b00, ad, 2'b00};
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    return {3'b000, d, 3'b000};
  endfunction

  function automatic vec_t mv(input logic a, b, na, input logic [37:0] j, input logic st,
                              input logic [31:0] rd, input logic er, erd, ewr, eerr,
                              input logic [31:0] ead, edr, ewd);
    vec_t v;
    v.a = a; v.b = b; v.na = na; v.j = j; v.stall = st; v.rdata = rd;
    v.e_ready = er; v.e_rd = erd; v.e_wr = ewr; v.e_err = eerr;
    v.e_addr = ead; v.e_dreg = edr; v.e_wdata = ewd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic a, b, na, input logic [37:0] j, input logic st, input logic [31:0] rd);
    ta_a = a; ta_b = b; tna_a = na; jdo = j; avm_waitrequest = st; avm_readdata = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference model
  logic        m_busy, m_is_wr, m_ready, m_err;
  logic [29:0] m_addr;
  logic [31:0] m_dreg, m_wdat;
  int          m_stalls;

  task automatic model_reset();
    m_busy = 0; m_is_wr = 0; m_ready = 1; m_err = 0;
    m_addr = '0; m_dreg = '0; m_wdat = '0; m_stalls = 0;
  endtask

  task automatic model_step(input logic a, b, na, input logic [37:0] j, input logic st, input logic [31:0] rd);
    if (m_busy) begin
      if (a || b || na) m_err = 1;
      if (!st) begin
        m_dreg  = m_is_wr ? m_wdat : rd;
        m_addr  = m_addr + 30'd1;
        m_ready = 1;
        m_busy  = 0;
      end else begin
        m_stalls++;
        if (m_stalls == 255) begin
          m_err = 1; m_ready = 1; m_busy = 0;
        end
      end
    end else if (b) begin
      m_wdat = j[34:3]; m_busy = 1; m_is_wr = 1; m_stalls = 0; m_ready = 0;
    end else if (a) begin
      m_addr = j[31:2];
      if (j[35]) m_err = 0;
      if (j[34]) begin
        m_busy = 1; m_is_wr = 0; m_stalls = 0; m_ready = 0;
      end
    end else if (na) begin
      m_busy = 1; m_is_wr = 0; m_stalls = 0; m_ready = 0;
    end
  endtask

  task automatic model_check();
    chk("rnd_ready", {31'd0, monitor_ready}, {31'd0, m_ready});
    chk("rnd_error", {31'd0, monitor_error}, {31'd0, m_err});
    chk("rnd_read",  {31'd0, avm_read},  {31'd0, m_busy && !m_is_wr});
    chk("rnd_write", {31'd0, avm_write}, {31'd0, m_busy && m_is_wr});
    chk("rnd_addr",  avm_address, m_busy ? {m_addr, 2'b00} : 32'd0);
    chk("rnd_dreg",  MonDReg, m_dreg);
    if (m_busy && m_is_wr) chk("rnd_wdata", avm_writedata, m_wdat);
  endtask

  initial begin
    int n;
    logic [63:0] r64;
    logic [37:0] jr;

    // addr 0x100 load, read, write, 3-wait auto-read, overrun, write-over-read priority, error clear
    vecs[0]  = mv(1,0,0, mk_a(30'h100,0,0), 0, 0,            1,0,0,0, 32'h0,   32'h0,        32'h0);
    vecs[1]  = mv(0,0,0, 38'h0,             0, 0,            1,0,0,0, 32'h0,   32'h0,        32'h0);
    vecs[2]  = mv(0,0,1, 38'h0,             0, 0,            0,1,0,0, 32'h400, 32'h0,        32'h0);
    vecs[3]  = mv(0,0,0, 38'h0,             0, 32'hCAFE0001, 1,0,0,0, 32'h0,   32'hCAFE0001, 32'h0);
    vecs[4]  = mv(0,1,0, mk_b(32'hDEADBEEF),0, 0,            0,0,1,0, 32'h404, 32'hCAFE0001, 32'hDEADBEEF);
    vecs[5]  = mv(0,0,0, 38'h0,             0, 0,            1,0,0,0, 32'h0,   32'hDEADBEEF, 32'h0);
    vecs[6]  = mv(1,0,0, mk_a(30'h200,1,0), 0, 0,            0,1,0,0, 32'h800, 32'hDEADBEEF, 32'h0);
    vecs[7]  = mv(0,0,0, 38'h0,             1, 0,            0,1,0,0, 32'h800, 32'hDEADBEEF, 32'h0);
    vecs[8]  = mv(0,0,0, 38'h0,             1, 0,            0,1,0,0, 32'h800, 32'hDEADBEEF, 32'h0);
    vecs[9]  = mv(0,0,0, 38'h0,             1, 0,            0,1,0,0, 32'h800, 32'hDEADBEEF, 32'h0);
    vecs[10] = mv(0,0,0, 38'h0,             0, 32'h12345678, 1,0,0,0, 32'h0,   32'h12345678, 32'h0);
    vecs[11] = mv(0,0,1, 38'h0,             0, 0,            0,1,0,0, 32'h804, 32'h12345678, 32'h0);
    vecs[12] = mv(0,0,1, 38'h0,             1, 0,            0,1,0,1, 32'h804, 32'h12345678, 32'h0);
    vecs[13] = mv(0,0,0, 38'h0,             0, 32'h0BADF00D, 1,0,0,1, 32'h0,   32'h0BADF00D, 32'h0);
    vecs[14] = mv(0,1,1, mk_b(32'h55AA55AA),0, 0,            0,0,1,1, 32'h808, 32'h0BADF00D, 32'h55AA55AA);
    vecs[15] = mv(0,0,0, 38'h0,             0, 0,            1,0,0,1, 32'h0,   32'h55AA55AA, 32'h0);
    vecs[16] = mv(1,0,0, mk_a(30'h0,0,1),   0, 0,            1,0,0,0, 32'h0,   32'h55AA55AA, 32'h0);

    reset_n = 1'b0;
    drive(0, 0, 0, 38'h0, 0, 32'h0);
    tick(); tick();
    chk("reset_dreg",  MonDReg, 32'h0);
    chk("reset_ready", {31'd0, monitor_ready}, 32'd1);
    chk("reset_error", {31'd0, monitor_error}, 32'd0);
    chk("reset_read",  {31'd0, avm_read}, 32'd0);
    chk("reset_write", {31'd0, avm_write}, 32'd0);
    chk("byteenable",  {28'd0, avm_byteenable}, 32'hF);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].na, vecs[i].j, vecs[i].stall, vecs[i].rdata);
      tick();
      chk($sformatf("vec%0d_ready", i), {31'd0, monitor_ready}, {31'd0, vecs[i].e_ready});
      chk($sformatf("vec%0d_read", i),  {31'd0, avm_read},      {31'd0, vecs[i].e_rd});
      chk($sformatf("vec%0d_write", i), {31'd0, avm_write},     {31'd0, vecs[i].e_wr});
      chk($sformatf("vec%0d_error", i), {31'd0, monitor_error}, {31'd0, vecs[i].e_err});
      chk($sformatf("vec%0d_addr", i),  avm_address, vecs[i].e_addr);
      chk($sformatf("vec%0d_dreg", i),  MonDReg, vecs[i].e_dreg);
      if (vecs[i].e_wr) chk($sformatf("vec%0d_wdata", i), avm_writedata, vecs[i].e_wdata);
    end

    // Timeout: stuck waitrequest aborts after 255 stalled request cycles
    drive(1, 0, 0, mk_a(30'h33, 1, 0), 1, 32'hFFFF0000);
    tick();
    drive(0, 0, 0, 38'h0, 1, 32'hFFFF0000);
    n = 0;
    while (avm_read && n < 400) begin
      n++;
      tick();
    end
    chk("timeout_cycles", n, 255);
    chk("timeout_error", {31'd0, monitor_error}, 32'd1);
    chk("timeout_ready", {31'd0, monitor_ready}, 32'd1);
    chk("timeout_dreg",  MonDReg, 32'h55AA55AA);
    drive(0, 0, 1, 38'h0, 0, 32'hA5A5A5A5);
    tick();
    chk("timeout_addr_kept", avm_address, 32'hCC);
    drive(0, 0, 0, 38'h0, 0, 32'hA5A5A5A5);
    tick();
    chk("post_timeout_dreg", MonDReg, 32'hA5A5A5A5);
    drive(1, 0, 0, mk_a(30'h0, 0, 1), 0, 0);
    tick();
    chk("clear_error", {31'd0, monitor_error}, 32'd0);

    // Address wrap at all-ones
    drive(1, 0, 0, mk_a(30'h3FFFFFFF, 1, 0), 0, 32'h1);
    tick();
    chk("wrap_addr_hi", avm_address, 32'hFFFFFFFC);
    drive(0, 0, 0, 38'h0, 0, 32'h1);
    tick();
    drive(0, 0, 1, 38'h0, 0, 32'h2);
    tick();
    chk("wrap_addr_lo", avm_address, 32'h0);
    chk("wrap_read", {31'd0, avm_read}, 32'd1);
    drive(0, 0, 0, 38'h0, 0, 32'h2);
    tick();

    // Reset in the middle of a stalled write
    drive(0, 1, 0, mk_b(32'h00001234), 1, 0);
    tick();
    drive(0, 0, 0, 38'h0, 1, 0);
    tick();
    chk("midwr_write", {31'd0, avm_write}, 32'd1);
    #2 reset_n = 1'b0;
    #1 chk("async_drop_write", {31'd0, avm_write}, 32'd0);
    tick();
    reset_n = 1'b1;
    drive(0, 0, 0, 38'h0, 0, 0);
    tick();
    chk("after_rst_ready", {31'd0, monitor_ready}, 32'd1);
    chk("after_rst_dreg",  MonDReg, 32'h0);
    chk("after_rst_write", {31'd0, avm_write}, 32'd0);

    // Random traffic against the model
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    model_reset();
    tick();
    for (int c = 0; c < 3000; c++) begin
      logic a, b, na, st;
      logic [31:0] rd;
      model_check();
      r64 = {$urandom(), $urandom()};
      jr  = r64[37:0];
      a   = ($urandom_range(0, 7) == 0);
      b   = ($urandom_range(0, 7) == 0);
      na  = ($urandom_range(0, 7) == 0);
      st  = ($urandom_range(0, 2) == 0);
      rd  = $urandom();
      drive(a, b, na, jr, st, rd);
      model_step(a, b, na, jr, st, rd);
      tick();
    end
    model_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
